// File: rtl/fft_out_reorder.sv
// fft_out_reorder: ping-pong buffer that re-emits bit-reversed FFT frames in natural order.
// Define FFT_OUT_REORDER_IDX_EN to add idx_o, the natural index of each output sample.
module fft_out_reorder #(
  parameter int DATA_W = 16,
  parameter int LOG2N  = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     valid_i,
  input  logic signed [DATA_W-1:0] data_in_r,
  input  logic signed [DATA_W-1:0] data_in_i,
  output logic                     valid_o,
  output logic                     sop_o,
  output logic signed [DATA_W-1:0] data_out_r,
  output logic signed [DATA_W-1:0] data_out_i
`ifdef FFT_OUT_REORDER_IDX_EN
  ,
  output logic [LOG2N-1:0]         idx_o
`endif
);
  localparam int N = 1 << LOG2N;
  typedef enum logic {IDLE, READ} state_t;
  state_t                state_q;
  logic [2*DATA_W-1:0]   mem_q [2][N];
  logic [LOG2N-1:0]      wr_cnt_q, wr_cnt_d, wr_addr, rd_cnt_q;
  logic                  wr_bank_q, wr_bank_d, rd_bank_q, frame_done, rd_reload;
  always_comb begin
    wr_addr = '0;
    for (int b = 0; b < LOG2N; b++) wr_addr[b] = wr_cnt_q[LOG2N-1-b];
  end
  assign frame_done = valid_i && (wr_cnt_q == LOG2N'(N-1));
  assign wr_cnt_d   = valid_i ? wr_cnt_q + LOG2N'(1) : wr_cnt_q;
  assign wr_bank_d  = wr_bank_q ^ frame_done;
  assign rd_reload  = (state_q == IDLE) || (rd_cnt_q == LOG2N'(N-1));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt_q  <= '0;
      wr_bank_q <= 1'b0;
    end else begin
      wr_cnt_q  <= wr_cnt_d;
      wr_bank_q <= wr_bank_d;
    end
  end
  always_ff @(posedge clk) begin
    if (valid_i) mem_q[wr_bank_q][wr_addr] <= {data_in_r, data_in_i};
  end
  // frame_done is combinational so X[0] leaves one edge after the last write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rd_bank_q  <= 1'b0;
      rd_cnt_q   <= '0;
      valid_o    <= 1'b0;
      sop_o      <= 1'b0;
      data_out_r <= '0;
      data_out_i <= '0;
`ifdef FFT_OUT_REORDER_IDX_EN
      idx_o      <= '0;
`endif
    end else begin
      valid_o                  <= state_q == READ;
      sop_o                    <= (state_q == READ) && (rd_cnt_q == '0);
      {data_out_r, data_out_i} <= (state_q == READ) ? mem_q[rd_bank_q][rd_cnt_q] : '0;
`ifdef FFT_OUT_REORDER_IDX_EN
      idx_o                    <= (state_q == READ) ? rd_cnt_q : '0;
`endif
      if (rd_reload) begin
        state_q   <= frame_done ? READ : IDLE;
        rd_bank_q <= frame_done ? wr_bank_q : rd_bank_q;
        rd_cnt_q  <= '0;
      end else begin
        rd_cnt_q  <= rd_cnt_q + LOG2N'(1);
      end
    end
  end
endmodule

// File: tb/tb_fft_out_reorder.sv
// tb_fft_out_reorder: directed bench for fft_out_reorder (idx_o checked when FFT_OUT_REORDER_IDX_EN is defined).
module tb_fft_out_reorder;
  logic               clk = 1'b0;
  logic               rst_n, valid_i, valid_o, sop_o;
  logic signed [15:0] din_r, din_i, dout_r, dout_i;
  int                 tests = 0;
  int                 fails = 0;
`ifdef FFT_OUT_REORDER_IDX_EN
  logic [4:0]         idx_o;
`endif

  fft_out_reorder #(.DATA_W(16), .LOG2N(5)) dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i),
    .data_in_r(din_r), .data_in_i(din_i),
    .valid_o(valid_o), .sop_o(sop_o),
    .data_out_r(dout_r), .data_out_i(dout_i)
`ifdef FFT_OUT_REORDER_IDX_EN
    , .idx_o(idx_o)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] br(input int k);
    logic [4:0] v, r;
    v = 5'(k);
    for (int i = 0; i < 5; i++) r[i] = v[4-i];
    return r;
  endfunction

  function automatic logic signed [15:0] nat_r(input int k);
    return k == 0 ? 16'sh8000 : k == 31 ? 16'sh7FFF : k == 16 ? 16'sh8000 : 16'(k * 3);
  endfunction

  function automatic logic signed [15:0] nat_i(input int k);
    return k == 0 ? 16'sh7FFF : k == 31 ? 16'sh8000 : k == 1 ? 16'shFFFF : 16'(-k * 5);
  endfunction

  task automatic cyc(input logic v, input logic signed [15:0] r, input logic signed [15:0] im);
    valid_i = v;
    din_r   = r;
    din_i   = im;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic ev, input logic es,
                     input logic signed [15:0] er, input logic signed [15:0] ei, input int ex);
    tests++;
    assert (valid_o === ev) else begin fails++; $error("FAIL %s[%0d] valid_o got %b exp %b", tag, ex, valid_o, ev); end
    tests++;
    assert (sop_o === es) else begin fails++; $error("FAIL %s[%0d] sop_o got %b exp %b", tag, ex, sop_o, es); end
    tests++;
    assert (dout_r === er) else begin fails++; $error("FAIL %s[%0d] data_out_r got %0d exp %0d", tag, ex, dout_r, er); end
    tests++;
    assert (dout_i === ei) else begin fails++; $error("FAIL %s[%0d] data_out_i got %0d exp %0d", tag, ex, dout_i, ei); end
`ifdef FFT_OUT_REORDER_IDX_EN
    tests++;
    assert (idx_o === (ev ? 5'(ex) : 5'd0)) else begin fails++; $error("FAIL %s[%0d] idx_o got %0d exp %0d", tag, ex, idx_o, ev ? ex : 0); end
`endif
  endtask

  task automatic idle(input string tag, input int n);
    for (int j = 0; j < n; j++) begin
      cyc(1'b0, 16'sd0, 16'sd0);
      chk(tag, 1'b0, 1'b0, 16'sd0, 16'sd0, j);
    end
  endtask

  initial begin
    rst_n = 1'b0; valid_i = 1'b0; din_r = '0; din_i = '0;
    #12;
    chk("reset", 1'b0, 1'b0, 16'sd0, 16'sd0, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    // single frame
    for (int k = 0; k < 32; k++) begin
      cyc(1'b1, 16'(br(k)), -16'(br(k)));
      chk("sf_in", 1'b0, 1'b0, 16'sd0, 16'sd0, k);
    end
    for (int k = 0; k < 32; k++) begin
      cyc(1'b0, 16'sd0, 16'sd0);
      chk("sf_out", 1'b1, k == 0, 16'(k), -16'(k), k);
    end
    idle("sf_end", 2);
    // back-to-back frames A then B
    for (int k = 0; k < 32; k++) begin
      cyc(1'b1, 16'(br(k)), -16'(br(k)));
      chk("bb_in", 1'b0, 1'b0, 16'sd0, 16'sd0, k);
    end
    for (int k = 0; k < 32; k++) begin
      cyc(1'b1, 16'(br(k)) + 16'sd100, -16'(br(k)));
      chk("bb_a", 1'b1, k == 0, 16'(k), -16'(k), k);
    end
    for (int k = 0; k < 32; k++) begin
      cyc(1'b0, 16'sd0, 16'sd0);
      chk("bb_b", 1'b1, k == 0, 16'(k + 100), -16'(k), k);
    end
    idle("bb_end", 2);
    // gapped input
    for (int k = 0; k < 32; k++) begin
      cyc(1'b1, 16'(br(k)) + 16'sd300, -16'(br(k)));
      chk("gap_in", 1'b0, 1'b0, 16'sd0, 16'sd0, k);
      if (k == 10) idle("gap_hole10", 3);
      if (k == 20) idle("gap_hole20", 1);
    end
    for (int k = 0; k < 32; k++) begin
      cyc(1'b0, 16'sd0, 16'sd0);
      chk("gap_out", 1'b1, k == 0, 16'(k + 300), -16'(k), k);
    end
    idle("gap_end", 2);
    // reset mid input frame
    for (int k = 0; k < 17; k++) begin
      cyc(1'b1, 16'(br(k)) + 16'sd50, 16'sd7);
      chk("rm_part", 1'b0, 1'b0, 16'sd0, 16'sd0, k);
    end
    valid_i = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rm_async", 1'b0, 1'b0, 16'sd0, 16'sd0, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 32; k++) begin
      cyc(1'b1, 16'(br(k)) + 16'sd200, -16'(br(k)));
      chk("rm_in", 1'b0, 1'b0, 16'sd0, 16'sd0, k);
    end
    for (int k = 0; k < 32; k++) begin
      cyc(1'b0, 16'sd0, 16'sd0);
      chk("rm_out", 1'b1, k == 0, 16'(k + 200), -16'(k), k);
    end
    idle("rm_end", 2);
    // reset during output at index 5
    for (int k = 0; k < 32; k++) begin
      cyc(1'b1, 16'(br(k)) + 16'sd400, -16'(br(k)));
      chk("ro_in", 1'b0, 1'b0, 16'sd0, 16'sd0, k);
    end
    for (int k = 0; k < 6; k++) begin
      cyc(1'b0, 16'sd0, 16'sd0);
      chk("ro_out", 1'b1, k == 0, 16'(k + 400), -16'(k), k);
    end
    rst_n = 1'b0;
    #1;
    chk("ro_async", 1'b0, 1'b0, 16'sd0, 16'sd0, 5);
    idle("ro_hold", 2);
    rst_n = 1'b1;
    idle("ro_after", 4);
    // signed extremes
    for (int k = 0; k < 32; k++) begin
      cyc(1'b1, nat_r(int'(br(k))), nat_i(int'(br(k))));
      chk("ext_in", 1'b0, 1'b0, 16'sd0, 16'sd0, k);
    end
    for (int k = 0; k < 32; k++) begin
      cyc(1'b0, 16'sd0, 16'sd0);
      chk("ext_out", 1'b1, k == 0, nat_r(k), nat_i(k), k);
    end
    idle("ext_end", 2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
